rca_alu: RTL and testbench

RCA_ALU -- requirements
Module: rca_alu

---
 rtl/rca_alu_pkg.sv | 28 ++
 rtl/rca_alu_bit.sv | 31 +++
 rtl/rca_alu.sv | 57 +++++
 tb/tb_rca_alu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rca_alu_pkg.sv
// Shared types and control encodings for the ripple-carry ALU.
// The control vector is ordered {InvA, InvB, cIn, ORen, FloodCarry}.
package rca_alu_pkg;

    typedef struct packed {
        logic inv_a;
        logic inv_b;
        logic c_in;
        logic or_en;
        logic flood_carry;
    } ctrl_t;

    localparam ctrl_t CTRL_ADD    = 5'b00000;
    localparam ctrl_t CTRL_ADD1   = 5'b00100;
    localparam ctrl_t CTRL_SUB    = 5'b01100;
    localparam ctrl_t CTRL_RSUB   = 5'b10100;
    localparam ctrl_t CTRL_OR     = 5'b00010;
    localparam ctrl_t CTRL_NOR    = 5'b00011;
    localparam ctrl_t CTRL_XNOR   = 5'b00001;
    localparam ctrl_t CTRL_AND    = 5'b11011;
    localparam ctrl_t CTRL_NAND   = 5'b11010;

    // Carry-derived flags are only meaningful when the ripple chain is live.
    function automatic logic is_arith(input logic or_en, input logic flood_carry);
        return !or_en && !flood_carry;
    endfunction

endpackage

// File: rtl/rca_alu_bit.sv
// One ripple-carry ALU bit cell: operand inversion, half-sum, carry generate and result.
module rca_alu_bit (
    input  logic a,
    input  logic b,
    input  logic InvA,
    input  logic InvB,
    input  logic ORen,
    input  logic FloodCarry,
    input  logic cI,
    output logic r,
    output logic cO
);

    logic a_i;
    logic b_i;
    logic p_i;
    logic g_i;
    logic h_i;
    logic e_i;

    assign a_i = a ^ InvA;
    assign b_i = b ^ InvB;
    assign p_i = a_i ^ b_i;
    assign g_i = a_i & b_i;
    assign h_i = ORen ? (a_i | b_i) : p_i;
    // cO is the raw ripple carry; ORen/FloodCarry only gate what this bit consumes.
    assign cO  = g_i | (p_i & cI);
    assign e_i = FloodCarry ? 1'b1 : (ORen ? 1'b0 : cI);
    assign r   = h_i ^ e_i;

endmodule

// File: rtl/rca_alu.sv
// Parameterised ripple-carry ALU with a one-cycle registered result and flags.
module rca_alu
    import rca_alu_pkg::*;
#(
    parameter int BitWidth = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                InvA,
    input  logic                InvB,
    input  logic                cIn,
    input  logic                ORen,
    input  logic                FloodCarry,
    input  logic [BitWidth-1:0] dINA,
    input  logic [BitWidth-1:0] dINB,
    output logic [BitWidth-1:0] dOUT,
    output logic                cOut,
    output logic                overflow,
    output logic                ifZero
);

    logic [BitWidth:0]   carry;
    logic [BitWidth-1:0] r;
    logic                arith;

    assign carry[0] = cIn;
    assign arith    = is_arith(ORen, FloodCarry);

    for (genvar i = 0; i < BitWidth; i++) begin : g_bit
        rca_alu_bit u_bit (
            .a          (dINA[i]),
            .b          (dINB[i]),
            .InvA       (InvA),
            .InvB       (InvB),
            .ORen       (ORen),
            .FloodCarry (FloodCarry),
            .cI         (carry[i]),
            .r          (r[i]),
            .cO         (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dOUT     <= '0;
            cOut     <= 1'b0;
            overflow <= 1'b0;
            ifZero   <= 1'b1;
        end else begin
            dOUT     <= r;
            cOut     <= arith & carry[BitWidth];
            overflow <= arith & (carry[BitWidth] ^ carry[BitWidth-1]);
            ifZero   <= ~|r;
        end
    end

endmodule

// File: tb/tb_rca_alu.sv
// Self-checking bench for rca_alu (BitWidth=4) using an expected-result queue.
module tb_rca_alu;
    import rca_alu_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         InvA, InvB, cIn, ORen, FloodCarry;
    logic [W-1:0] dINA, dINB;
    logic [W-1:0] dOUT;
    logic         cOut, overflow, ifZero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    rca_alu #(.BitWidth(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .InvA       (InvA),
        .InvB       (InvB),
        .cIn        (cIn),
        .ORen       (ORen),
        .FloodCarry (FloodCarry),
        .dINA       (dINA),
        .dINB       (dINB),
        .dOUT       (dOUT),
        .cOut       (cOut),
        .overflow   (overflow),
        .ifZero     (ifZero)
    );

    always #5 clk = ~clk;

    // Behavioural reference: operation-level, not bit-cell level.
    function automatic exp_t model(input ctrl_t c, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        exp_t       e;
        logic [W-1:0] a, b;
        logic [W:0] sum;
        a = a_in ^ {W{c.inv_a}};
        b = b_in ^ {W{c.inv_b}};
        e.co = 1'b0;
        e.ov = 1'b0;
        if (c.flood_carry) begin
            e.d = c.or_en ? ~(a | b) : ~(a ^ b);
        end else if (c.or_en) begin
            e.d = a | b;
        end else begin
            sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c.c_in};
            e.d  = sum[W-1:0];
            e.co = sum[W];
            e.ov = (a[W-1] == b[W-1]) && (e.d[W-1] != a[W-1]);
        end
        e.z = (e.d == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] d, input logic co, input logic ov, input logic z);
        exp_t e;
        e.d  = d;
        e.co = co;
        e.ov = ov;
        e.z  = z;
        return e;
    endfunction

    task automatic drive(input logic r, input ctrl_t c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e);
        @(negedge clk);
        rst = r;
        {InvA, InvB, cIn, ORen, FloodCarry} = c;
        dINA = a;
        dINB = b;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t got, exp;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, CTRL_ADD, 4'b0011, 4'b0101, mk(4'b0000, 1'b0, 1'b0, 1'b1));
            @(posedge clk); #1;
            got = {dOUT, cOut, overflow, ifZero};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_directed();
        exp_t   got, exp;
        ctrl_t  c[10];
        logic [W-1:0] a[10], b[10];
        exp_t   e[10];
        c[0] = CTRL_ADD;  a[0] = 4'b0011; b[0] = 4'b0101; e[0] = mk(4'b1000, 0, 1, 0);
        c[1] = CTRL_SUB;  a[1] = 4'b0101; b[1] = 4'b0101; e[1] = mk(4'b0000, 1, 0, 1);
        c[2] = CTRL_OR;   a[2] = 4'b0011; b[2] = 4'b0101; e[2] = mk(4'b0111, 0, 0, 0);
        c[3] = CTRL_NOR;  a[3] = 4'b0011; b[3] = 4'b0101; e[3] = mk(4'b1000, 0, 0, 0);
        c[4] = CTRL_XNOR; a[4] = 4'b0011; b[4] = 4'b0101; e[4] = mk(4'b1001, 0, 0, 0);
        c[5] = CTRL_AND;  a[5] = 4'b0011; b[5] = 4'b0101; e[5] = mk(4'b0001, 0, 0, 0);
        c[6] = CTRL_NAND; a[6] = 4'b0011; b[6] = 4'b0101; e[6] = mk(4'b1110, 0, 0, 0);
        c[7] = CTRL_ADD;  a[7] = 4'b1111; b[7] = 4'b0001; e[7] = mk(4'b0000, 1, 0, 1);
        c[8] = CTRL_SUB;  a[8] = 4'b1000; b[8] = 4'b0001; e[8] = mk(4'b0111, 1, 1, 0);
        c[9] = CTRL_RSUB; a[9] = 4'b0010; b[9] = 4'b0111; e[9] = mk(4'b0101, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, c[i], a[i], b[i], e[i]);
            @(posedge clk); #1;
            got = {dOUT, cOut, overflow, ifZero};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL directed[%0d] ctrl=%b a=%b b=%b: got %b required %b",
                         i, c[i], a[i], b[i], got, exp);
            end
        end
    endtask

    task automatic test_all_controls();
        exp_t         got, exp;
        ctrl_t        c;
        logic [W-1:0] a, b;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 3; j++) begin
                c = ctrl_t'(k[4:0]);
                a = W'($urandom_range(0, 15));
                b = W'($urandom_range(0, 15));
                drive(1'b0, c, a, b, model(c, a, b));
                @(posedge clk); #1;
                got = {dOUT, cOut, overflow, ifZero};
                exp = sb_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL ctrl_sweep ctrl=%b a=%b b=%b: got %b required %b", c, a, b, got, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t         got, exp;
        ctrl_t        c;
        logic [W-1:0] a, b;
        // Exhaustive ADD and SUB, one new operand pair every cycle.
        for (int k = 0; k < 512; k++) begin
            c = k[8] ? CTRL_SUB : CTRL_ADD;
            a = k[7:4];
            b = k[3:0];
            drive(1'b0, c, a, b, model(c, a, b));
            @(posedge clk); #1;
            got = {dOUT, cOut, overflow, ifZero};
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back ctrl=%b a=%b b=%b: got %b required %b", c, a, b, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t got, exp;
        drive(1'b0, CTRL_ADD, 4'b0011, 4'b0101, mk(4'b1000, 0, 1, 0));
        @(posedge clk); #1;
        got = {dOUT, cOut, overflow, ifZero};
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b required %b", got, exp);
        end
        // A reset pulse that never spans a rising edge must leave outputs alone.
        #1 rst = 1'b1;
        #1 got = {dOUT, cOut, overflow, ifZero};
        rst = 1'b0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_between_edges: got %b required %b", got, exp);
        end
        drive(1'b1, CTRL_ADD, 4'b0011, 4'b0101, mk(4'b0000, 0, 0, 1));
        @(posedge clk); #1;
        got = {dOUT, cOut, overflow, ifZero};
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_assert: got %b required %b", got, exp);
        end
        drive(1'b0, CTRL_ADD, 4'b0011, 4'b0101, mk(4'b1000, 0, 1, 0));
        @(posedge clk); #1;
        got = {dOUT, cOut, overflow, ifZero};
        exp = sb_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_release: got %b required %b", got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {InvA, InvB, cIn, ORen, FloodCarry} = 5'b00000;
        dINA = '0;
        dINB = '0;
        test_reset();
        test_directed();
        test_all_controls();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
